// File: rtl/sd_spi_host.sv
// SD card SPI-mode host: single-block CMD17 read / CMD24 write.
// Frames the command with CRC-7 and moves one 64-bit block with CRC-16.
module sd_spi_host #(
  parameter logic [5:0]  CMD_RD = 6'd17,
  parameter logic [5:0]  CMD_WR = 6'd24,
  parameter int unsigned WR_GAP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_wr,
  input  logic [15:0] in_addr,
  input  logic [63:0] in_data,
  input  logic        MISO,
  output logic        MOSI,
  output logic        busy,
  output logic        out_valid,
  output logic [63:0] out_data,
  output logic        err
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD_TX,
    S_RESP_WAIT,
    S_RESP_RX,
    S_TOKEN_WAIT,
    S_RD_DATA,
    S_RD_CRC,
    S_WR_GAP,
    S_WR_TOKEN,
    S_WR_DATA,
    S_WR_CRC,
    S_DRESP_WAIT,
    S_DRESP_RX,
    S_BUSY_WAIT,
    S_DONE
  } state_t;

  localparam logic [7:0] GAP_LAST = 8'(WR_GAP - 1);

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [15:0] crc16(input logic [63:0] d);
    logic [15:0] c;
    logic        fb;
    c = '0;
    for (int i = 63; i >= 0; i--) begin
      fb = d[i] ^ c[15];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  state_t      state, state_d;
  logic [7:0]  cnt, cnt_d;
  logic        wr_q;
  logic [63:0] data_q;
  logic [87:0] tx_sr;
  logic [15:0] crc_rx;
  logic [7:0]  resp_q;
  logic [39:0] hdr;
  logic        tx_active;

  assign hdr = {2'b01, in_wr ? CMD_WR : CMD_RD,
                16'h0, in_addr};

  assign tx_active = state inside {S_CMD_TX, S_WR_TOKEN,
                                   S_WR_DATA, S_WR_CRC};

  assign MOSI      = tx_active ? tx_sr[87] : 1'b1;
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);
  assign out_data  = (out_valid && !wr_q) ? data_q : '0;
  assign err       = out_valid &&
                     (wr_q ? (resp_q != 8'h05)
                           : (crc_rx != crc16(data_q)));

  always_comb begin
    state_d = state;
    cnt_d   = cnt + 8'd1;
    unique case (state)
      S_IDLE: begin
        cnt_d = '0;
        if (in_valid) state_d = S_CMD_TX;
      end
      S_CMD_TX: begin
        if (cnt == 8'd47) begin
          state_d = S_RESP_WAIT;
          cnt_d   = '0;
        end
      end
      S_RESP_WAIT: begin
        cnt_d = '0;
        if (!MISO) state_d = S_RESP_RX;
      end
      // a stray 1 simply terminates R1 early
      S_RESP_RX: begin
        if (MISO || cnt == 8'd6) begin
          cnt_d   = '0;
          state_d = wr_q ? S_WR_GAP : S_TOKEN_WAIT;
        end
      end
      S_TOKEN_WAIT: begin
        cnt_d = '0;
        if (!MISO) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (cnt == 8'd63) begin
          state_d = S_RD_CRC;
          cnt_d   = '0;
        end
      end
      S_RD_CRC: begin
        if (cnt == 8'd15) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      S_WR_GAP: begin
        if (cnt == GAP_LAST) begin
          state_d = S_WR_TOKEN;
          cnt_d   = '0;
        end
      end
      S_WR_TOKEN: begin
        if (cnt == 8'd7) begin
          state_d = S_WR_DATA;
          cnt_d   = '0;
        end
      end
      S_WR_DATA: begin
        if (cnt == 8'd63) begin
          state_d = S_WR_CRC;
          cnt_d   = '0;
        end
      end
      S_WR_CRC: begin
        if (cnt == 8'd15) begin
          state_d = S_DRESP_WAIT;
          cnt_d   = '0;
        end
      end
      S_DRESP_WAIT: begin
        cnt_d = '0;
        if (!MISO) state_d = S_DRESP_RX;
      end
      S_DRESP_RX: begin
        if (cnt == 8'd6) begin
          state_d = S_BUSY_WAIT;
          cnt_d   = '0;
        end
      end
      S_BUSY_WAIT: begin
        cnt_d = '0;
        if (MISO) state_d = S_DONE;
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      wr_q   <= 1'b0;
      data_q <= '0;
      tx_sr  <= '1;
      crc_rx <= '0;
      resp_q <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            wr_q   <= in_wr;
            data_q <= in_data;
            tx_sr  <= {hdr, crc7(hdr), 1'b1,
                       40'hFF_FFFF_FFFF};
          end
        end
        S_CMD_TX, S_WR_TOKEN, S_WR_DATA, S_WR_CRC:
          tx_sr <= {tx_sr[86:0], 1'b1};
        S_WR_GAP: begin
          if (cnt == GAP_LAST)
            tx_sr <= {8'hFE, data_q, crc16(data_q)};
        end
        S_RD_DATA:
          data_q <= {data_q[62:0], MISO};
        S_RD_CRC:
          crc_rx <= {crc_rx[14:0], MISO};
        // shifting while waiting leaves the last 8 bits
        S_DRESP_WAIT, S_DRESP_RX:
          resp_q <= {resp_q[6:0], MISO};
        default: ;
      endcase
    end
  end

endmodule
